// File: rtl/vending_pkg.sv
// vending_pkg: shared definitions for the customer-side vending buyer.
// Holds coin values and price (in half-yuan units), the status codes
// reported with po_done, and the one-hot FSM state encoding.
package vending_pkg;

    // Coin values and price expressed in half-yuan units.
    localparam logic [2:0] HALF_VAL  = 3'd1;
    localparam logic [2:0] ONE_VAL   = 3'd2;
    localparam logic [2:0] PRICE     = 3'd4;
    // Largest total that can ever be reached: 3 halves + 1 one, or 1 half + 2 ones.
    localparam logic [2:0] TOTAL_MAX = 3'd5;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_INSUFF  = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_UNEXP   = 2'b11
    } status_t;

    typedef enum logic [4:0] {
        S_IDLE      = 5'b00001,
        S_INSERT    = 5'b00010,
        S_GAP       = 5'b00100,
        S_WAIT_COLA = 5'b01000,
        S_DONE      = 5'b10000
    } state_t;

endpackage

// File: rtl/vending_buyer_if.sv
// vending_buyer_if: groups the purchase request, machine feedback and
// buyer result signals.
//   master: the buyer (drives coin pulses and results, reads requests/feedback)
//   slave : the environment (drives requests and machine feedback)
interface vending_buyer_if;
    logic       pi_start;
    logic [2:0] pi_half_cnt;
    logic [1:0] pi_one_cnt;
    logic       pi_cola;
    logic       pi_change_half;
    logic       po_money_half;
    logic       po_money_one;
    logic       po_busy;
    logic       po_done;
    logic [1:0] po_status;
    logic [2:0] po_left_half;
    logic [1:0] po_left_one;
    logic [7:0] po_cola_cnt;

    modport master (
        input  pi_start, pi_half_cnt, pi_one_cnt, pi_cola, pi_change_half,
        output po_money_half, po_money_one, po_busy, po_done, po_status,
               po_left_half, po_left_one, po_cola_cnt
    );

    modport slave (
        output pi_start, pi_half_cnt, pi_one_cnt, pi_cola, pi_change_half,
        input  po_money_half, po_money_one, po_busy, po_done, po_status,
               po_left_half, po_left_one, po_cola_cnt
    );
endinterface

// File: rtl/vending_down_cnt.sv
// vending_down_cnt: loadable down-counter with a zero flag.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over dec)
//   dec        : decrement by one, holding at zero
//   load_val   : value to load
//   zero       : count is zero
module vending_down_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over decrement; the counter never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/vending_buyer.sv
// vending_buyer: customer-side driver for the vending machine coin inputs.
// On start it inserts half coins then one coins as single-cycle pulses until
// the price is covered, waits for the cola pulse, checks the change and
// reports status, unused coins and a saturating count of good purchases.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   bus (master)       : request/feedback inputs and registered results
module vending_buyer #(
    parameter int GAP     = 1,
    parameter int TIMEOUT = 8
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    vending_buyer_if.master bus
);
    import vending_pkg::*;

    // Counter reload values: the counter reaches zero on the last cycle of
    // the gap / timeout window, so it is loaded with the length minus one.
    localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    state_t     state, state_n;
    status_t    status_q, status_n;
    logic [2:0] half_q, half_n, total_q, total_n, src_h, src_t, left_half_q;
    logic [1:0] one_q, one_n, src_o, left_one_q;
    logic [7:0] cola_cnt_q, cnt_val;
    logic       coin_half_q, coin_one_q, busy_q, done_q;
    logic       coin_half_n, coin_one_n, issue, enter_done;
    logic       cnt_load, cnt_dec, cnt_zero, abort;

    assign abort      = bus.pi_cola | bus.pi_change_half;
    assign enter_done = (state_n == S_DONE);

    vending_down_cnt #(.WIDTH(8)) u_timer (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Next-state logic. A coin is registered onto the line at the edge that
    // enters INSERT, so "issue" selects the count/total source that coin is
    // taken from; half coins always go before one coins.
    always_comb begin
        state_n     = state;
        status_n    = status_q;
        half_n      = half_q;
        one_n       = one_q;
        total_n     = total_q;
        issue       = 1'b0;
        src_h       = half_q;
        src_o       = one_q;
        src_t       = total_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_val     = 8'd0;
        coin_half_n = 1'b0;
        coin_one_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.pi_start) begin
                    half_n  = bus.pi_half_cnt;
                    one_n   = bus.pi_one_cnt;
                    total_n = 3'd0;
                    if ((bus.pi_half_cnt == 3'd0) && (bus.pi_one_cnt == 2'd0)) begin
                        state_n  = S_DONE;
                        status_n = ST_INSUFF;
                    end else begin
                        state_n = S_INSERT;
                        issue   = 1'b1;
                        src_h   = bus.pi_half_cnt;
                        src_o   = bus.pi_one_cnt;
                        src_t   = 3'd0;
                    end
                end
            end
            S_INSERT: begin
                if (abort) begin
                    state_n  = S_DONE;
                    status_n = ST_UNEXP;
                end else if (total_q >= PRICE) begin
                    state_n  = S_WAIT_COLA;
                    cnt_load = 1'b1;
                    cnt_val  = TMO_LOAD;
                end else if ((half_q != 3'd0) || (one_q != 2'd0)) begin
                    if (GAP > 0) begin
                        state_n  = S_GAP;
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LOAD;
                    end else begin
                        issue = 1'b1;
                    end
                end else begin
                    state_n  = S_DONE;
                    status_n = ST_INSUFF;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_n  = S_DONE;
                    status_n = ST_UNEXP;
                end else if (cnt_zero) begin
                    state_n = S_INSERT;
                    issue   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_WAIT_COLA: begin
                if (bus.pi_cola) begin
                    state_n  = S_DONE;
                    status_n = (bus.pi_change_half == (total_q == TOTAL_MAX)) ? ST_OK : ST_UNEXP;
                end else if (cnt_zero) begin
                    state_n  = S_DONE;
                    status_n = ST_TIMEOUT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (issue) begin
            if (src_h != 3'd0) begin
                coin_half_n = 1'b1;
                half_n      = src_h - 3'd1;
                one_n       = src_o;
                total_n     = src_t + HALF_VAL;
            end else begin
                coin_one_n = 1'b1;
                half_n     = src_h;
                one_n      = src_o - 2'd1;
                total_n    = src_t + ONE_VAL;
            end
        end
    end

    // State and registered outputs. Results are captured only on entry to
    // DONE so they stay stable until the next purchase finishes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            status_q    <= ST_OK;
            half_q      <= 3'd0;
            one_q       <= 2'd0;
            total_q     <= 3'd0;
            coin_half_q <= 1'b0;
            coin_one_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            left_half_q <= 3'd0;
            left_one_q  <= 2'd0;
            cola_cnt_q  <= 8'd0;
        end else begin
            state       <= state_n;
            half_q      <= half_n;
            one_q       <= one_n;
            total_q     <= total_n;
            coin_half_q <= coin_half_n;
            coin_one_q  <= coin_one_n;
            busy_q      <= (state_n == S_INSERT) || (state_n == S_GAP) || (state_n == S_WAIT_COLA);
            done_q      <= enter_done;
            if (enter_done) begin
                status_q    <= status_n;
                left_half_q <= half_n;
                left_one_q  <= one_n;
                if ((status_n == ST_OK) && (cola_cnt_q != 8'hFF)) begin
                    cola_cnt_q <= cola_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.po_money_half = coin_half_q;
    assign bus.po_money_one  = coin_one_q;
    assign bus.po_busy       = busy_q;
    assign bus.po_done       = done_q;
    assign bus.po_status     = status_q;
    assign bus.po_left_half  = left_half_q;
    assign bus.po_left_one   = left_one_q;
    assign bus.po_cola_cnt   = cola_cnt_q;

endmodule

// File: tb/tb_vending_buyer.sv
// tb_vending_buyer: two buyers (GAP=0/TIMEOUT=3 and GAP=2/TIMEOUT=8) share
// the stimulus; sel picks which one receives the start and feedback and whose
// outputs are compared. Each purchase is planned from the coin rules with
// plain arithmetic, then the outputs are compared cycle by cycle.
module tb_vending_buyer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       start, cola, chg;
    logic [2:0] hcnt;
    logic [1:0] ocnt;

    int checks   = 0;
    int failures = 0;
    int model_cnt [2];

    vending_buyer_if bus0 ();
    vending_buyer_if bus1 ();

    assign bus0.pi_start       = start & ~sel;
    assign bus1.pi_start       = start & sel;
    assign bus0.pi_half_cnt    = hcnt;
    assign bus1.pi_half_cnt    = hcnt;
    assign bus0.pi_one_cnt     = ocnt;
    assign bus1.pi_one_cnt     = ocnt;
    assign bus0.pi_cola        = cola & ~sel;
    assign bus1.pi_cola        = cola & sel;
    assign bus0.pi_change_half = chg & ~sel;
    assign bus1.pi_change_half = chg & sel;

    logic       m_half, m_one, m_busy, m_done;
    logic [1:0] m_status, m_lo;
    logic [2:0] m_lh;
    logic [7:0] m_cnt;

    assign m_half   = sel ? bus1.po_money_half : bus0.po_money_half;
    assign m_one    = sel ? bus1.po_money_one  : bus0.po_money_one;
    assign m_busy   = sel ? bus1.po_busy       : bus0.po_busy;
    assign m_done   = sel ? bus1.po_done       : bus0.po_done;
    assign m_status = sel ? bus1.po_status     : bus0.po_status;
    assign m_lh     = sel ? bus1.po_left_half  : bus0.po_left_half;
    assign m_lo     = sel ? bus1.po_left_one   : bus0.po_left_one;
    assign m_cnt    = sel ? bus1.po_cola_cnt   : bus0.po_cola_cnt;

    vending_buyer #(.GAP(0), .TIMEOUT(3)) u_dut0 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus0)
    );

    vending_buyer #(.GAP(2), .TIMEOUT(8)) u_dut1 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_half"},   32'(m_half),   0);
        checkOutput({tag, "_one"},    32'(m_one),    0);
        checkOutput({tag, "_busy"},   32'(m_busy),   0);
        checkOutput({tag, "_done"},   32'(m_done),   0);
        checkOutput({tag, "_status"}, 32'(m_status), 0);
        checkOutput({tag, "_lhalf"},  32'(m_lh),     0);
        checkOutput({tag, "_lone"},   32'(m_lo),     0);
        checkOutput({tag, "_cnt"},    32'(m_cnt),    0);
    endtask

    // One purchase on buyer s with h half / o one coins.
    // mode 0: honest machine, 1: machine never delivers, 2: feedback pulse
    // during coin insertion, 3: cola with the wrong change indication.
    task automatic applyStimulus(input int s, input int h, input int o, input int mode, input bit busy_start);
        int gapv, tmov, total, rh, ro, n, t, p, a, done_cyc, cola_cyc, chg_cyc;
        int exp_status, exp_lh, exp_lo;
        int coin_cyc [8];
        bit coin_hf  [8];
        gapv  = (s != 0) ? 2 : 0;
        tmov  = (s != 0) ? 8 : 3;
        total = 0; rh = h; ro = o; n = 0; t = 1;
        while ((total < 4) && ((rh + ro) > 0)) begin
            if (rh > 0) begin coin_hf[n] = 1'b1; rh--; total += 1; end
            else        begin coin_hf[n] = 1'b0; ro--; total += 2; end
            coin_cyc[n] = t;
            n++;
            t += gapv + 1;
        end
        p = (n > 0) ? coin_cyc[n-1] : 0;
        cola_cyc = -1; chg_cyc = -1;
        exp_lh = rh; exp_lo = ro;
        if (n == 0) begin
            done_cyc = 1; exp_status = 1;
        end else if (mode == 2) begin
            a = int'($urandom_range(p, 1));
            if ($urandom_range(1, 0) == 1) cola_cyc = a; else chg_cyc = a;
            exp_lh = h; exp_lo = o;
            for (int i = 0; i < n; i++) begin
                if (coin_cyc[i] <= a) begin
                    if (coin_hf[i]) exp_lh--; else exp_lo--;
                end
            end
            for (int i = 0; i < 8; i++) if (i >= n || coin_cyc[i] > a) coin_cyc[i] = -1;
            done_cyc = a + 1; exp_status = 3;
        end else if (total < 4) begin
            done_cyc = p + 1; exp_status = 1;
        end else if (mode == 1) begin
            done_cyc = p + tmov + 1; exp_status = 2;
        end else begin
            cola_cyc = p + 1;
            if ((total == 5) != (mode == 3)) chg_cyc = p + 1;
            done_cyc = p + 2;
            exp_status = (mode == 3) ? 3 : 0;
        end
        if ((exp_status == 0) && (model_cnt[s] < 255)) model_cnt[s]++;

        @(negedge clk);
        sel = (s != 0); hcnt = 3'(h); ocnt = 2'(o); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            bit eh, eo;
            eh = 1'b0; eo = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (coin_cyc[i] == c) begin
                    if (coin_hf[i]) eh = 1'b1; else eo = 1'b1;
                end
            end
            checkOutput("coin_half", 32'(m_half), 32'(eh));
            checkOutput("coin_one",  32'(m_one),  32'(eo));
            checkOutput("busy",      32'(m_busy), 32'(c < done_cyc));
            checkOutput("done",      32'(m_done), 32'(c == done_cyc));
            if (c >= done_cyc) begin
                checkOutput("status",    32'(m_status), 32'(exp_status));
                checkOutput("left_half", 32'(m_lh),     32'(exp_lh));
                checkOutput("left_one",  32'(m_lo),     32'(exp_lo));
                checkOutput("cola_cnt",  32'(m_cnt),    32'(model_cnt[s]));
            end
            cola  = (c == cola_cyc);
            chg   = (c == chg_cyc);
            start = busy_start && (c == 2) && (c < done_cyc);
            if (start) begin
                hcnt = 3'($urandom_range(7, 0));
                ocnt = 2'($urandom_range(3, 0));
            end
            @(negedge clk);
        end
        cola = 1'b0; chg = 1'b0; start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sel = 1'b0; cola = 1'b0; chg = 1'b0;
        hcnt = 3'd0; ocnt = 2'd0;
        model_cnt[0] = 0; model_cnt[1] = 0;
        repeat (2) @(negedge clk);
        checkAllZero("reset0");
        sel = 1'b1; #1;
        checkAllZero("reset1");
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, 4, 0, 0, 1'b0);
        applyStimulus(1, 1, 2, 0, 1'b0);
        applyStimulus(0, 2, 0, 0, 1'b0);
        applyStimulus(1, 0, 2, 1, 1'b0);
        applyStimulus(1, 3, 1, 2, 1'b1);
        applyStimulus(0, 0, 0, 0, 1'b0);
        applyStimulus(0, 0, 3, 3, 1'b0);
        applyStimulus(1, 1, 3, 0, 1'b0);
        applyStimulus(0, 3, 1, 2, 1'b1);
        applyStimulus(0, 0, 1, 1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            applyStimulus(int'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
                          int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                          1'($urandom_range(1, 0)));
        end

        // Asynchronous reset while the first coin is on the line.
        @(negedge clk);
        sel = 1'b1; hcnt = 3'd3; ocnt = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("pre_reset_coin", 32'(m_half), 1);
        #2 rst_n = 1'b0;
        #1 checkAllZero("midreset");
        model_cnt[0] = 0; model_cnt[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1, 3, 1, 0, 1'b0);

        // Enough good purchases to drive the count into saturation.
        for (int k = 0; k < 260; k++) begin
            applyStimulus(0, int'($urandom_range(7, 4)), int'($urandom_range(3, 0)), 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
